act_feeder: RTL
===============

// Module: act_feeder
// PURPOSE
// - Upstream stage of input_buffer: fetches activation vectors (one per row slot) from activation SRAM and pushes them
//   into input_buffer via in_act/load_en/out_en, then flushes the per-row skew with zero vectors.
// - Sits between the top-level controller (start/done) and input_buffer; the systolic array can stall it.
// PARAMETERS
// - ARRAY_W   default `ARRAYWIDTH (8)  number of array rows = lanes per vector
// - DATA_W    default `DATASIZE (8)    bits per activation element (signed two's complement)
// - ADDR_W    default 10               SRAM word-address width; one word = one vector
// - CNT_W     default 10               width of num_vec
// PORTS
// - clk          in   1               clock, all logic on posedge
// - rst          in   1               asynchronous, active-low reset
// - start        in   1               one-cycle request; sampled only in IDLE
// - base_addr    in   ADDR_W          first SRAM word of the sequence, latched on accepted start
// - num_vec      in   CNT_W           number of vectors to fetch, latched on accepted start
// - stall        in   1               array back-pressure; 1 = no push this cycle
// - mem_rd_en    out  1               SRAM read strobe
// - mem_addr     out  ADDR_W          SRAM read address
// - mem_rd_data  in   ARRAY_W*DATA_W  SRAM data, valid exactly 1 cycle after mem_rd_en
// - in_act       out  ARRAY_W*DATA_W  vector to input_buffer; lane i = bits [(i+1)*DATA_W-1:i*DATA_W]
// - load_en      out  1               push strobe to input_buffer
// - out_en       out  1               shift strobe to input_buffer; always equal to load_en
// - busy         out  1               high from accepted start until done
// - done         out  1               one-cycle pulse when the sequence is fully pushed
// BEHAVIOUR
// - Reset (rst=0, async): all outputs 0, FSM=IDLE, counters 0, hold register empty.
// - FSM: IDLE -> FETCH on start (num_vec!=0); IDLE -> FIN on start with num_vec==0 (no reads, no pushes).
//   FETCH -> DRAIN when the last real vector has been pushed.
//   DRAIN -> FIN after exactly ARRAY_W-1 zero-vector pushes (ARRAY_W==1: zero pushes, straight to FIN).
//   FIN -> IDLE next cycle; done=1 only during the FIN cycle.
// - busy = (state != IDLE); start while busy is ignored (no effect, no error).
// - Read issue (FETCH): mem_rd_en=1 when reads_issued<num_vec, stall==0, and (hold empty or hold pushed this cycle);
//   mem_addr = base_addr + reads_issued, wrap modulo 2^ADDR_W; mem_addr holds its last value when mem_rd_en=0.
// - Return: data from the read at cycle t is captured into a 1-entry hold register at t+1, even if stall=1 then.
// - Push: load_en=out_en=1 in any cycle where stall==0 and (hold valid in FETCH, or state==DRAIN);
//   in_act = hold data (FETCH) or all zeros (DRAIN); in_act is 0 in every non-push cycle.
// - Throughput: 1 vector/cycle with stall=0; first push 2 cycles after the accepted start
//   (start@0, read@1, push@2); done at cycle num_vec+ARRAY_W+1.
// - Stall: no push, no new read while stall=1; a read already in flight is held, never lost or duplicated; order preserved.
// - Counters: reads_issued and pushes are CNT_W bits; num_vec = 2^CNT_W-1 is legal and must not overflow.
// - Reset mid-sequence: immediate abort to IDLE, no done pulse; the next start after reset release is accepted normally.
// CONFIGURATION
// - ACT_RELU_EN defined: each lane of real (FETCH) vectors is clamped at push time: a negative element
//   (MSB=1) becomes 0; zero-flush vectors are unaffected.
// - ACT_RELU_EN undefined: in_act passes SRAM data bit-exact; no clamp logic present.
// TESTING
// - ARRAY_W=4, num_vec=3, base 0x10, stall=0 -> reads 0x10,0x11,0x12 at cycles 1-3; pushes at 2-4 with data;
//   zero pushes at 5-7; done at cycle 8.
// - num_vec=0 -> no mem_rd_en, no load_en, busy 1 cycle, done pulse on cycle 1.
// - num_vec=4, stall high cycles 3-5 -> push order/data unchanged; exactly 4 data + ARRAY_W-1 zero pushes; done delayed by 3.
// - base_addr=2^ADDR_W-2, num_vec=4 -> addresses max-1, max, 0, 1.
// - rst low mid-FETCH -> all outputs 0 asynchronously, no done; new start (num_vec=2) completes correctly.
// - ACT_RELU_EN, SRAM lane = 8'h85 and 8'h05 -> in_act lanes 8'h00 and 8'h05; undefined -> 8'h85 passed.

Source files
------------

// File: rtl/act_feeder.sv
// act_feeder: fetches num_vec activation vectors from SRAM starting at base_addr,
// pushes them into input_buffer (load_en/out_en/in_act), then flushes the per-row
// skew with ARRAY_W-1 zero vectors and pulses done.
// Optional build macro: ACT_RELU_EN -- clamps negative lanes of fetched vectors to 0.

`ifndef ARRAYWIDTH
`define ARRAYWIDTH 8
`endif
`ifndef DATASIZE
`define DATASIZE 8
`endif

module act_feeder #(
  parameter int ARRAY_W = `ARRAYWIDTH,
  parameter int DATA_W  = `DATASIZE,
  parameter int ADDR_W  = 10,
  parameter int CNT_W   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [CNT_W-1:0]          num_vec,
  input  logic                      stall,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [ARRAY_W*DATA_W-1:0] mem_rd_data,
  output logic [ARRAY_W*DATA_W-1:0] in_act,
  output logic                      load_en,
  output logic                      out_en,
  output logic                      busy,
  output logic                      done
);

  localparam int VEC_W      = ARRAY_W * DATA_W;
  localparam int DCNT_W     = (ARRAY_W > 1) ? $clog2(ARRAY_W) : 1;
  localparam int DRAIN_LAST = (ARRAY_W > 1) ? ARRAY_W - 2 : 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  reads_q;
  logic [CNT_W-1:0]  pushes_q;
  logic [DCNT_W-1:0] drain_q;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;   // a read was issued last cycle; its data is on mem_rd_data now
  logic              hold_full_q;  // returned data parked because the push was stalled
  logic [VEC_W-1:0]  hold_data_q;

  logic              in_idle, in_fetch, in_drain;
  logic              avail;
  logic              push;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [VEC_W-1:0]  cur_data;
  logic [VEC_W-1:0]  fetch_vec;
  logic              last_push;
  logic              last_drain;

  assign in_idle  = (state_q == S_IDLE);
  assign in_fetch = (state_q == S_FETCH);
  assign in_drain = (state_q == S_DRAIN);

  // Returning data is usable the cycle it arrives; the hold register only covers stalls,
  // so both are never occupied at once (a new read needs the hold to empty first).
  assign avail    = inflight_q | hold_full_q;
  assign cur_data = hold_full_q ? hold_data_q : mem_rd_data;

  assign push  = !stall && ((in_fetch && avail) || in_drain);
  assign rd_en = in_fetch && (reads_q < num_q) && !stall && (!avail || push);

  assign rd_addr   = base_q + ADDR_W'(reads_q);
  assign mem_rd_en = rd_en;
  assign mem_addr  = rd_en ? rd_addr : addr_q;

  assign last_push  = in_fetch && push && (pushes_q == (num_q - CNT_W'(1)));
  assign last_drain = in_drain && push && (drain_q == DCNT_W'(DRAIN_LAST));

  for (genvar gi = 0; gi < ARRAY_W; gi++) begin : g_lane
    logic [DATA_W-1:0] lane;
    assign lane = cur_data[gi*DATA_W +: DATA_W];
`ifdef ACT_RELU_EN
    assign fetch_vec[gi*DATA_W +: DATA_W] = lane[DATA_W-1] ? '0 : lane;
`else
    assign fetch_vec[gi*DATA_W +: DATA_W] = lane;
`endif
  end

  assign in_act  = (push && in_fetch) ? fetch_vec : '0;
  assign load_en = push;
  assign out_en  = push;
  assign busy    = !in_idle;
  assign done    = (state_q == S_FIN);

  // Next-state selection for the fetch / drain / finish sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (num_vec == '0) ? S_FIN : S_FETCH;
      S_FETCH: if (last_push) state_d = (ARRAY_W > 1) ? S_DRAIN : S_FIN;
      S_DRAIN: if (last_drain) state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any sequence without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Sequence parameters, counters, read tracking and the stall hold register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q      <= '0;
      num_q       <= '0;
      reads_q     <= '0;
      pushes_q    <= '0;
      drain_q     <= '0;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
    end else begin
      if (in_idle && start) begin
        base_q   <= base_addr;
        num_q    <= num_vec;
        reads_q  <= '0;
        pushes_q <= '0;
        drain_q  <= '0;
      end
      if (rd_en) begin
        reads_q <= reads_q + CNT_W'(1);
        addr_q  <= rd_addr;
      end
      inflight_q <= rd_en;
      if (inflight_q && !push) begin
        hold_full_q <= 1'b1;
        hold_data_q <= mem_rd_data;
      end else if (push && in_fetch) begin
        hold_full_q <= 1'b0;
      end
      if (push && in_fetch) pushes_q <= pushes_q + CNT_W'(1);
      if (push && in_drain) drain_q <= drain_q + DCNT_W'(1);
    end
  end

endmodule
